// File: rtl/cpu_isa_pkg.sv
// ISA constants, ALU/writeback codes and sequencer state encodings shared by the
// multi-cycle controller and the debug display.
package cpu_isa_pkg;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int IMM4_HI = 3;
  localparam int IMM4_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_LI   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_PASS_B = 3'd4;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_IMM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST,
      OP_BEQ, OP_JMP, OP_LI, OP_HALT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Loads/stores reuse ADD for rs+imm4; BEQ compares with SUB.
  function automatic logic [2:0] aluOpFor(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_LI:          return ALU_PASS_B;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the sequencer and the surrounding datapath.
interface multicycle_ctrl_if #(parameter int PC_W = 8);

  logic            run;
  logic            step;
  logic [15:0]     ir;
  logic            zero;
  logic            mem_ack;
  logic            ir_load;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic            mem_req;
  logic            mem_we;
  logic            mem_addr_sel;
  logic [2:0]      alu_op;
  logic            alu_bsel;
  logic            rf_we;
  logic [1:0]      rf_wsel;
  logic [2:0]      state;
  logic            halted;
  logic            illegal;
  logic            mem_err;

  modport slave (
    input  run, step, ir, zero, mem_ack,
    output ir_load, pc_inc, pc_load, pc_target, mem_req, mem_we, mem_addr_sel,
           alu_op, alu_bsel, rf_we, rf_wsel, state, halted, illegal, mem_err
  );

  modport master (
    output run, step, ir, zero, mem_ack,
    input  ir_load, pc_inc, pc_load, pc_target, mem_req, mem_we, mem_addr_sel,
           alu_op, alu_bsel, rf_we, rf_wsel, state, halted, illegal, mem_err
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles and flags the one
// that brings the count up to MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_waiting;

  assign w_waiting = i_req & ~i_ack;

  // Saturating so a stuck request can never wrap back below the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (!w_waiting)
      r_cnt <= '0;
    else if (r_cnt != CNT_W'(MAX_WAIT))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_timeout = w_waiting && (r_cnt >= CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath,
// with memory wait-state handshake and timeout protection.
module multicycle_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               CLK,
  input logic               RSTn,
  multicycle_ctrl_if.slave  bus
);

  state_t          r_state;
  logic [3:0]      r_op;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_target;
  logic [2:0]      r_alu_op;
  logic            r_alu_bsel;
  logic [1:0]      r_rf_wsel;
  logic            r_halted;
  logic            r_mem_err;

  logic [3:0]      w_op;
  logic [PC_W-1:0] w_sext_imm;
  logic            w_req;
  logic            w_fetch_done;
  logic            w_mem_done;
  logic            w_pc_load;
  logic            w_timeout;
  state_t          w_retire;

  assign w_op         = bus.ir[OP_HI:OP_LO];
  assign w_sext_imm   = {{(PC_W-4){bus.ir[IMM4_HI]}}, bus.ir[IMM4_HI:IMM4_LO]};
  assign w_req        = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_fetch_done = (r_state == S_FETCH) && bus.mem_ack;
  assign w_mem_done   = (r_state == S_MEM) && bus.mem_ack;
  assign w_pc_load    = (r_state == S_EXEC) &&
                        ((r_op == OP_JMP) || ((r_op == OP_BEQ) && bus.zero));
  assign w_retire     = bus.run ? S_FETCH : S_IDLE;

  mem_wait_timer #(.MAX_WAIT(MEM_TIMEOUT)) u_timer (
    .i_clk     (CLK),
    .i_rst_n   (RSTn),
    .i_req     (w_req),
    .i_ack     (bus.mem_ack),
    .o_timeout (w_timeout)
  );

  // Shadow of the datapath PC so BEQ targets can be formed from the incremented PC.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      r_pc <= '0;
    else if (w_pc_load)
      r_pc <= r_pc_target;
    else if (w_fetch_done)
      r_pc <= r_pc + PC_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_alu_op    <= ALU_ADD;
      r_alu_bsel  <= 1'b0;
      r_rf_wsel   <= WSEL_ALU;
      r_pc_target <= '0;
      r_halted    <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (bus.run || bus.step) r_state <= S_FETCH;
        S_FETCH:
          if (w_fetch_done) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_err <= 1'b1;
          end
        S_DECODE: begin
          r_op        <= w_op;
          r_alu_op    <= aluOpFor(w_op);
          r_alu_bsel  <= (w_op == OP_LD) || (w_op == OP_ST) || (w_op == OP_LI);
          r_rf_wsel   <= (w_op == OP_LD) ? WSEL_MEM :
                         (w_op == OP_LI) ? WSEL_IMM : WSEL_ALU;
          r_pc_target <= (w_op == OP_JMP) ? bus.ir[PC_W-1:0] : r_pc + w_sext_imm;
          if (w_op == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if ((w_op == OP_NOP) || !isLegalOp(w_op)) begin
            r_state <= w_retire;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC:
          case (r_op)
            OP_LD, OP_ST:   r_state <= S_MEM;
            OP_BEQ, OP_JMP: r_state <= w_retire;
            default:        r_state <= S_WB;
          endcase
        S_MEM:
          if (w_mem_done) begin
            r_state <= (r_op == OP_LD) ? S_WB : w_retire;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_err <= 1'b1;
          end
        S_WB:
          r_state <= w_retire;
        S_HALT:
          r_state <= S_HALT;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ir_load      = w_fetch_done;
  assign bus.pc_inc       = w_fetch_done;
  assign bus.pc_load      = w_pc_load;
  assign bus.pc_target    = r_pc_target;
  assign bus.mem_req      = w_req;
  assign bus.mem_addr_sel = (r_state == S_MEM);
  assign bus.mem_we       = (r_state == S_MEM) && (r_op == OP_ST);
  assign bus.alu_op       = r_alu_op;
  assign bus.alu_bsel     = r_alu_bsel;
  assign bus.rf_we        = (r_state == S_WB);
  assign bus.rf_wsel      = r_rf_wsel;
  assign bus.state        = r_state;
  assign bus.halted       = r_halted;
  assign bus.illegal      = (r_state == S_DECODE) && !isLegalOp(w_op);
  assign bus.mem_err      = r_mem_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized single-step instruction bench for multicycle_ctrl, plus directed
// run-mode, HALT, timeout and asynchronous-reset scenarios.
module tb_multicycle_ctrl;

  localparam int PC_W = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int errCount = 0;
  int checkCount = 0;
  logic [PC_W-1:0] modelPc;

  multicycle_ctrl_if #(.PC_W(PC_W)) bus ();

  multicycle_ctrl #(.PC_W(PC_W), .MEM_TIMEOUT(15)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction in single-step mode with fW fetch and mW data wait states;
  // stepAt>0 fires a spurious step pulse mid-instruction.
  task automatic applyStimulus(input logic [15:0] word, input logic z,
                               input int fW, input int mW, input int stepAt);
    logic [3:0] op;
    bit isAlu, isLd, isSt, isBeq, isJmp, isLi, isExec, taken;
    int expCyc, expReq, expData, expMemWe, expRfwe, expIll, s, wt, reqCnt;
    int cyc, nIrl, nInc, nLoad, nRfwe, nMemWe, nReq, nData, nIll;
    bit phaseDone, sawExec;
    logic [PC_W-1:0] expTgt, tgt;
    logic [1:0] expWsel, wsel;
    logic [2:0] expAlu, aop;
    logic expBsel, bsel;
    string t;

    op     = word[15:12];
    isAlu  = (op >= 4'h1) && (op <= 4'h4);
    isLd   = (op == 4'h8);
    isSt   = (op == 4'h9);
    isBeq  = (op == 4'hA);
    isJmp  = (op == 4'hB);
    isLi   = (op == 4'hC);
    isExec = isAlu || isLd || isSt || isBeq || isJmp || isLi;
    expCyc   = (fW + 1) + 1 + (isExec ? 1 : 0) + ((isLd || isSt) ? mW + 1 : 0) +
               ((isAlu || isLi || isLd) ? 1 : 0);
    expReq   = (fW + 1) + ((isLd || isSt) ? mW + 1 : 0);
    expData  = (isLd || isSt) ? mW + 1 : 0;
    expMemWe = isSt ? mW + 1 : 0;
    expRfwe  = (isAlu || isLi || isLd) ? 1 : 0;
    expWsel  = isLd ? 2'd1 : (isLi ? 2'd2 : 2'd0);
    expIll   = (isExec || op == 4'h0) ? 0 : 1;
    taken    = isJmp || (isBeq && z);
    s        = word[3] ? int'(word[3:0]) - 16 : int'(word[3:0]);
    expTgt   = isJmp ? word[7:0] : PC_W'((int'(modelPc) + 1 + s) & 255);
    expAlu   = isAlu ? 3'(op - 4'h1) : (isBeq ? 3'd1 : (isLi ? 3'd4 : 3'd0));
    expBsel  = isLd || isSt || isLi;
    t = $sformatf("op%h@%0h", op, modelPc);

    cyc = 0; nIrl = 0; nInc = 0; nLoad = 0; nRfwe = 0; nMemWe = 0;
    nReq = 0; nData = 0; nIll = 0; reqCnt = 0; phaseDone = 0; sawExec = 0;
    tgt = '0; wsel = '0; aop = '0; bsel = 1'b0;

    @(negedge CLK);
    bus.ir = word; bus.zero = z; bus.step = 1'b1; bus.mem_ack = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      bus.step = 1'b0;
      if (bus.state == ST_IDLE) break;
      if (stepAt != 0 && cyc == stepAt) bus.step = 1'b1;
      if (bus.mem_req) begin
        if (phaseDone) begin reqCnt = 0; phaseDone = 0; end
        reqCnt++;
        wt = bus.mem_addr_sel ? mW : fW;
        bus.mem_ack = (reqCnt > wt);
        phaseDone = bus.mem_ack;
      end else begin
        bus.mem_ack = 1'($urandom);
        reqCnt = 0; phaseDone = 0;
      end
      #1;
      if (bus.ir_load) nIrl++;
      if (bus.pc_inc) nInc++;
      if (bus.pc_load) begin nLoad++; tgt = bus.pc_target; end
      if (bus.rf_we) begin nRfwe++; wsel = bus.rf_wsel; end
      if (bus.mem_we) nMemWe++;
      if (bus.mem_req) nReq++;
      if (bus.mem_req && bus.mem_addr_sel) nData++;
      if (bus.illegal) nIll++;
      if (bus.state == ST_EXEC) begin sawExec = 1; aop = bus.alu_op; bsel = bus.alu_bsel; end
      cyc++;
    end
    bus.step = 1'b0;

    checkOutput({t, " cycles"}, cyc, expCyc);
    checkOutput({t, " ir_load"}, nIrl, 1);
    checkOutput({t, " pc_inc"}, nInc, 1);
    checkOutput({t, " mem_req"}, nReq, expReq);
    checkOutput({t, " data_req"}, nData, expData);
    checkOutput({t, " mem_we"}, nMemWe, expMemWe);
    checkOutput({t, " rf_we"}, nRfwe, expRfwe);
    checkOutput({t, " illegal"}, nIll, expIll);
    checkOutput({t, " pc_load"}, nLoad, taken ? 1 : 0);
    if (expRfwe != 0) checkOutput({t, " rf_wsel"}, wsel, expWsel);
    if (taken) checkOutput({t, " pc_target"}, tgt, expTgt);
    if (isExec && !isJmp) begin
      checkOutput({t, " exec"}, sawExec, 1);
      checkOutput({t, " alu_op"}, aop, expAlu);
      checkOutput({t, " alu_bsel"}, bsel, expBsel);
    end
    repeat (2) @(negedge CLK);
    #1 checkOutput({t, " stays idle"}, bus.state, ST_IDLE);
    modelPc = taken ? expTgt : PC_W'(modelPc + 1);
  endtask

  task automatic resetDut(input string tag);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    checkOutput({tag, " state"}, bus.state, ST_IDLE);
    checkOutput({tag, " halted"}, bus.halted, 0);
    checkOutput({tag, " mem_err"}, bus.mem_err, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    modelPc = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] expSeq [4];
    int n, seen;
    logic [15:0] w;

    bus.run = 1'b0; bus.step = 1'b0; bus.ir = '0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    modelPc = '0;
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst state", bus.state, ST_IDLE);
    checkOutput("rst mem_req", bus.mem_req, 0);
    checkOutput("rst rf_we", bus.rf_we, 0);
    checkOutput("rst pc_target", bus.pc_target, 0);
    checkOutput("rst alu_op", bus.alu_op, 0);
    checkOutput("rst halted", bus.halted, 0);
    checkOutput("rst mem_err", bus.mem_err, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    applyStimulus(16'hC1FF, 1'b0, 0, 0, 0);
    applyStimulus(16'h1123, 1'b0, 0, 0, 0);
    applyStimulus(16'h8231, 1'b0, 0, 3, 0);
    applyStimulus(16'hA11E, 1'b1, 0, 0, 0);
    applyStimulus(16'hA11E, 1'b0, 0, 0, 0);
    applyStimulus(16'h7000, 1'b0, 0, 0, 0);
    applyStimulus(16'hC1FF, 1'b0, 0, 0, 2);
    applyStimulus(16'h9231, 1'b0, 2, 1, 3);
    applyStimulus(16'hB042, 1'b0, 1, 0, 1);
    for (int i = 0; i < 40; i++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      applyStimulus(w, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3));
    end

    // Free-running LI with memory always ready
    expSeq[0] = ST_FETCH; expSeq[1] = ST_DECODE; expSeq[2] = ST_EXEC; expSeq[3] = ST_WB;
    @(negedge CLK);
    bus.ir = 16'hC1FF; bus.mem_ack = 1'b1; bus.run = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      checkOutput($sformatf("run state%0d", i + 1), bus.state, expSeq[i]);
      if (bus.pc_inc) n++;
      if (i == 3) begin
        checkOutput("run rf_we", bus.rf_we, 1);
        checkOutput("run rf_wsel", bus.rf_wsel, 2);
      end
    end
    checkOutput("run pc_inc", n, 1);
    @(negedge CLK);
    checkOutput("run refetch", bus.state, ST_FETCH);
    bus.run = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (bus.state == ST_IDLE) begin seen = 1; break; end
    end
    checkOutput("run drop idle", seen, 1);

    // HALT is absorbing
    @(negedge CLK);
    bus.ir = 16'hF000; bus.mem_ack = 1'b1; bus.step = 1'b1;
    @(negedge CLK);
    bus.step = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("halt state", bus.state, ST_HALT);
    checkOutput("halt halted", bus.halted, 1);
    checkOutput("halt mem_err", bus.mem_err, 0);
    bus.run = 1'b1; bus.step = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("halt sticky", bus.state, ST_HALT);
    checkOutput("halt no req", bus.mem_req, 0);
    bus.run = 1'b0; bus.step = 1'b0; bus.mem_ack = 1'b0;
    resetDut("rst after halt");

    // Fetch never acknowledged
    @(negedge CLK);
    bus.step = 1'b1; bus.mem_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      bus.step = 1'b0;
      #1;
      if (bus.mem_err) break;
      if (bus.mem_req) n++;
    end
    checkOutput("timeout wait cycles", n, 15);
    checkOutput("timeout mem_err", bus.mem_err, 1);
    checkOutput("timeout halted", bus.halted, 1);
    checkOutput("timeout state", bus.state, ST_HALT);
    resetDut("rst after timeout");

    // Reset in the middle of a store's MEM wait
    @(negedge CLK);
    bus.ir = 16'h9231; bus.step = 1'b1; bus.mem_ack = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      bus.step = 1'b0;
      if (bus.state == ST_MEM) begin seen = 1; break; end
      bus.mem_ack = (bus.state == ST_FETCH);
    end
    checkOutput("st reached mem", seen, 1);
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("st mem_req", bus.mem_req, 1);
    checkOutput("st mem_we", bus.mem_we, 1);
    checkOutput("st addr_sel", bus.mem_addr_sel, 1);
    #2 RSTn = 1'b0;
    #1;
    checkOutput("async mem_req", bus.mem_req, 0);
    checkOutput("async mem_we", bus.mem_we, 0);
    checkOutput("async state", bus.state, ST_IDLE);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      checkOutput("post rst rf_we", bus.rf_we, 0);
      checkOutput("post rst mem_we", bus.mem_we, 0);
      checkOutput("post rst state", bus.state, ST_IDLE);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
